// File: rtl/seq_divider_unit.sv
// seq_divider_unit: iterative restoring divider, unsigned or truncating signed,
// with a one-cycle divide-by-zero path and a start/ready/done handshake.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// OP    | one restoring step per cycle, WIDTH steps
// FIX   | sign correction and result write
// DONE  | one-cycle done pulse

module seq_divider_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH:0]   acc_shift;

  always_comb begin
    dividend_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    // The partial remainder is always below the divisor, so its top bit is
    // only needed transiently for the shifted compare.
    acc_shift    = {acc_q, q_q[WIDTH-1]};

    state_d     = state_q;
    acc_d       = acc_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_quo_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_mode & dividend[WIDTH-1];
          q_d       = dividend_mag;
          dvs_d     = divisor_mag;
          acc_d     = '0;
          cnt_d     = CW'(WIDTH);
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = OP;
          end
        end
      end
      OP: begin
        if (acc_shift >= {1'b0, dvs_q}) begin
          acc_d = WIDTH'(acc_shift - {1'b0, dvs_q});
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = acc_shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = neg_quo_q ? -q_q : q_q;
        remainder_d = neg_rem_q ? -acc_q : acc_q;
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign ready       = ready_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_divider_unit.sv
// Bench for seq_divider_unit: directed cases at WIDTH=8 plus randomised
// operations at WIDTH=2, 8 and 16 against an integer-arithmetic model.

module tb_seq_divider_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_x;
  logic        in_sm;
  logic [15:0] in_a, in_b;
  int          sel_w;

  always #5 clk = ~clk;

  logic        st2, st8, st16;
  logic [1:0]  q2, r2;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;
  logic        rdy2, dn2, z2, rdy8, dn8, z8, rdy16, dn16, z16;

  assign st2  = start_x && (sel_w == 2);
  assign st8  = start_x && (sel_w == 8);
  assign st16 = start_x && (sel_w == 16);

  seq_divider_unit #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .signed_mode(in_sm),
    .dividend(in_a[1:0]), .divisor(in_b[1:0]),
    .quotient(q2), .remainder(r2), .ready(rdy2), .done(dn2), .div_by_zero(z2));

  seq_divider_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(in_sm),
    .dividend(in_a[7:0]), .divisor(in_b[7:0]),
    .quotient(q8), .remainder(r8), .ready(rdy8), .done(dn8), .div_by_zero(z8));

  seq_divider_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(in_sm),
    .dividend(in_a), .divisor(in_b),
    .quotient(q16), .remainder(r16), .ready(rdy16), .done(dn16), .div_by_zero(z16));

  logic [15:0] mq, mr;
  logic        mrdy, mdn, mz;

  always_comb begin
    mq = '0; mr = '0; mrdy = 1'b0; mdn = 1'b0; mz = 1'b0;
    case (sel_w)
      2:       begin mq = {14'd0, q2}; mr = {14'd0, r2}; mrdy = rdy2; mdn = dn2; mz = z2; end
      8:       begin mq = {8'd0, q8};  mr = {8'd0, r8};  mrdy = rdy8; mdn = dn8; mz = z8; end
      default: begin mq = q16;         mr = r16;         mrdy = rdy16; mdn = dn16; mz = z16; end
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // last expected result per width, indexed 0:W2 1:W8 2:W16
  logic [15:0] pq[3];
  logic [15:0] pr[3];
  logic        pz[3];

  function automatic int wi(input int w);
    return (w == 2) ? 0 : (w == 8) ? 1 : 2;
  endfunction

  function automatic void ref_div(input int w, input bit sm, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] q,
                                  output logic [15:0] r, output logic z);
    longint m, ua, ub, sa, sb, qq, rr, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    if (ub == 0) begin
      q = 16'(m); r = 16'(ua); z = 1'b1;
      return;
    end
    z = 1'b0;
    if (sm) begin
      sa = (ua >= half) ? ua - (m + 1) : ua;
      sb = (ub >= half) ? ub - (m + 1) : ub;
      qq = sa / sb;
      rr = sa % sb;
    end else begin
      qq = ua / ub;
      rr = ua % ub;
    end
    q = 16'(qq & m);
    r = 16'(rr & m);
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    @(negedge clk);
    while (!mrdy && t < 100) begin @(negedge clk); t++; end
    chk(tag, 32'(mrdy), 32'd1);
  endtask

  task automatic run_op(input int w, input bit sm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez,
                        input bit poke);
    int k = wi(w);
    int lat = -1;
    int busy = 0;
    int dones = 0;
    bit early_bad = 0;
    bit zero;
    logic [15:0] m;
    m    = 16'((longint'(1) << w) - 1);
    zero = ((b & m) == 16'd0);
    sel_w = w;
    wait_ready("ready_before_start");
    in_sm = sm; in_a = a; in_b = b; start_x = 1'b1;
    @(posedge clk);
    #1;
    start_x = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_sm = 1'($urandom);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mrdy) break;
      busy++;
      if (mdn) begin
        dones++;
        if (lat < 0) lat = i;
      end else if (lat < 0 && (mq !== pq[k] || mr !== pr[k] || mz !== pz[k])) begin
        early_bad = 1'b1;
      end
      if (poke && i == 2) begin
        start_x = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom) | 16'd1;
      end else begin
        start_x = 1'b0;
      end
    end
    start_x = 1'b0;
    chk("latency", 32'(lat), zero ? 32'd0 : 32'(w + 1));
    chk("busy_cycles", 32'(busy), zero ? 32'd1 : 32'(w + 2));
    chk("done_pulses", 32'(dones), 32'd1);
    chk("stable_during_op", 32'(early_bad), 32'd0);
    chk("quotient", 32'(mq), 32'(eq));
    chk("remainder", 32'(mr), 32'(er));
    chk("div_by_zero", 32'(mz), 32'(ez));
    @(negedge clk);
    @(negedge clk);
    chk("hold_idle", {mq, mr}, {eq, er});
    pq[k] = eq; pr[k] = er; pz[k] = ez;
  endtask

  task automatic run_rand(input int w, input int n);
    logic [15:0] m, mn, a, b, eq, er;
    logic        ez;
    bit          sm;
    m  = 16'((longint'(1) << w) - 1);
    mn = 16'(longint'(1) << (w - 1));
    for (int i = 0; i < n; i++) begin
      a  = 16'($urandom) & m;
      b  = 16'($urandom) & m;
      sm = 1'($urandom);
      case (i)
        0: begin a = 16'd0; if (b == 16'd0) b = 16'd1; end
        1: b = 16'd1;
        2: begin a = mn; b = 16'd1; end
        3: begin a = m; b = m; end
        4: begin a = mn; b = m; sm = 1'b1; end
        5: b = 16'd0;
        default: if ($urandom_range(3) == 0) b = b & 16'd3;
      endcase
      ref_div(w, sm, a, b, eq, er, ez);
      run_op(w, sm, a, b, eq, er, ez, (i % 5) == 2);
    end
  endtask

  int done_at[$];
  int dn_cnt;

  initial begin
    rst = 1'b1; start_x = 1'b0; in_sm = 1'b0; in_a = '0; in_b = '0; sel_w = 8;
    for (int i = 0; i < 3; i++) begin pq[i] = '0; pr[i] = '0; pz[i] = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(mrdy), 32'd1);
    chk("reset_done", 32'(mdn), 32'd0);
    chk("reset_results", {mq, mr}, 32'd0);
    chk("reset_dbz", 32'(mz), 32'd0);
    rst = 1'b0;

    run_op(8, 0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 0);
    run_op(8, 1, 16'h00F9, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 0);
    run_op(8, 1, 16'h0007, 16'h00FE, 16'h00FD, 16'h0001, 1'b0, 0);
    run_op(8, 1, 16'h00F9, 16'h00FE, 16'h0003, 16'h00FF, 1'b0, 0);
    run_op(8, 1, 16'h0080, 16'h00FF, 16'h0080, 16'h0000, 1'b0, 0);
    run_op(8, 0, 16'h0055, 16'h0000, 16'h00FF, 16'h0055, 1'b1, 0);
    run_op(8, 1, 16'h0055, 16'h0000, 16'h00FF, 16'h0055, 1'b1, 0);
    run_op(8, 0, 16'd9,    16'd3,    16'd3,    16'd0,    1'b0, 0);
    run_op(8, 0, 16'd200,  16'd13,   16'd15,   16'd5,    1'b0, 1);

    // reset at OP step 4
    sel_w = 8;
    wait_ready("ready_before_reset_op");
    in_sm = 1'b0; in_a = 16'd100; in_b = 16'd7; start_x = 1'b1;
    @(posedge clk);
    #1 start_x = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(mrdy), 32'd1);
    chk("midrst_done", 32'(mdn), 32'd0);
    chk("midrst_results", {mq, mr}, 32'd0);
    chk("midrst_dbz", 32'(mz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn_cnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (mdn) dn_cnt++; end
    chk("midrst_no_done", 32'(dn_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin pq[i] = '0; pr[i] = '0; pz[i] = 1'b0; end
    run_op(8, 0, 16'd255, 16'd16, 16'd15, 16'd15, 1'b0, 0);

    // back-to-back with start held high
    sel_w = 8;
    wait_ready("ready_before_b2b");
    in_sm = 1'b0; in_a = 16'd100; in_b = 16'd7; start_x = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mdn) done_at.push_back(i);
    end
    start_x = 1'b0;
    chk("b2b_count", 32'(done_at.size() >= 4), 32'd1);
    for (int j = 1; j < done_at.size(); j++)
      chk("b2b_spacing", 32'(done_at[j] - done_at[j-1]), 32'd11);
    chk("b2b_result", {mq, mr}, {16'd14, 16'd2});
    wait_ready("ready_after_b2b");
    pq[1] = 16'd14; pr[1] = 16'd2; pz[1] = 1'b0;

    run_rand(2, 30);
    run_rand(8, 30);
    run_rand(16, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_unit.md
# seq_divider_unit

Parametrised iterative restoring divider with integrated control and datapath. Supports unsigned and signed (truncating) division selected per operation, divide-by-zero detection with a one-cycle fast path, and a start/ready/done handshake. It is the next-generation divider for the hierarchical design examples and is self-contained, with no external datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- signed_mode  in  1  sampled at accept; 1 = two's-complement operands.
- dividend  in  WIDTH  sampled at accept.
- divisor  in  WIDTH  sampled at accept.
- quotient  out  WIDTH  registered result; held until next result write.
- remainder  out  WIDTH  registered result; held until next result write.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- div_by_zero  out  1  registered flag for the last completed operation; updated with results.

## Operation
- States: IDLE, OP, FIX, DONE.
- **IDLE** (ready=1): on start, capture the following, then go to OP, or to DONE if divisor==0.
  - sign flags: quotient negative = signed_mode & (sign(dividend) ^ sign(divisor)); remainder negative = signed_mode & sign(dividend).
  - magnitudes |dividend| and |divisor|. Negation is done in WIDTH bits; |MIN| = 2^(WIDTH-1) is representable unsigned.
  - iteration counter = WIDTH, of width $clog2(WIDTH+1).
- **OP**: one restoring step per cycle.
  - Compute R' = {R[WIDTH-1:0], Q[WIDTH-1]} with R WIDTH+1 bits, initially 0.
  - If R' ≥ D: R = R' − D, shift 1 into Q. Else R = R', shift 0 into Q.
  - Q is initialised to the dividend magnitude. The counter decrements each step.
  - Go to FIX on the step where the counter goes 1→0.
- **FIX**: write quotient = neg_q ? −Q : Q and remainder = neg_r ? −R[WIDTH-1:0] : R[WIDTH-1:0], both mod 2^WIDTH. Clear div_by_zero. Go to DONE.
- **Divide-by-zero path**: at accept, write quotient = all ones, remainder = dividend unchanged, div_by_zero = 1, and go directly to DONE. This is identical for signed and unsigned.
- **DONE**: done=1, ready=0; go to IDLE next edge.
- **Signed overflow**: MIN / −1 yields quotient = MIN, remainder = 0, div_by_zero = 0. This falls out of the magnitude arithmetic with no special case.
- start while not in IDLE is ignored; no queueing. start held high in IDLE after DONE starts a new operation.
- State encoding default: unreachable codes go to IDLE.

## Timing
- Reset (async assert, deasserted synchronously by the environment): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0. The counter and internal registers clear.
- Reset mid-operation aborts immediately. The result registers clear, and no done pulse is issued for the aborted operation.
- Normal latency: accept at edge 0.
  - OP steps occur on edges 1..WIDTH; FIX is the cycle after edge WIDTH.
  - The result is written and done asserted after edge WIDTH+1. ready returns after edge WIDTH+2.
  - Throughput is one operation per WIDTH+3 cycles.
- Divide-by-zero latency: done is asserted the cycle after the accept edge (after edge 0 → DONE at edge 1... i.e. the DONE state is entered at edge 0). ready returns after edge 1.
- quotient, remainder and div_by_zero change only on the result-write edge (FIX→DONE, or accept on zero divisor) and at reset. They are stable during IDLE and OP.

## Test plan
- **Unsigned:** WIDTH=8, signed_mode=0, 100/7 → quotient=14, remainder=2, div_by_zero=0; done exactly 9 cycles after the accept edge (WIDTH+1); ready low for 10 cycles.
- **Signed mixes:** signed_mode=1 → −7/2 gives q=0xFD, r=0xFF; 7/−2 gives q=0xFD, r=0x01; −7/−2 gives q=0x03, r=0xFF; 0x80/0xFF gives q=0x80, r=0x00.
- **Divide by zero:** 0x55/0 in both modes → q=0xFF, r=0x55, div_by_zero=1; done one cycle after accept. A subsequent 9/3 clears div_by_zero and gives q=3, r=0.
- **Busy-start and hold:** pulse start with new operands during OP → ignored, results match the first operation. Operand inputs changed mid-operation do not affect results. Results are held stable through the following IDLE.
- **Mid-operation reset:** assert rst at OP step 4 → immediately ready=1, done=0, outputs 0; no done pulse afterwards. A new 255/16 then completes with q=15, r=15.
- **Back-to-back and parameter sweep:** start held high → back-to-back operations every WIDTH+3 cycles. Randomised checks against a reference model for WIDTH=2, 8, 16 include 0/x, x/1, MIN/1 and max/max.
